// File: rtl/usb_tx_sched_if.sv
// usb_tx_sched_if: byte-serial handshake between the packet scheduler and the
// USB transmitter. The scheduler is the master (drives data/valid), the
// transmitter is the slave (returns the per-byte ready strobe and line busy).
interface usb_tx_sched_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy
    );
endinterface

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: packet-level transmit scheduler. Arbitrates a handshake
// (PID-only) requester and a data (PID + payload + CRC16) requester, streams
// the packet bytes to the transmitter, then holds an inter-packet gap.
// Optional build macro USB_TX_SCHED_RR_EN selects round-robin arbitration;
// without it the handshake path has fixed priority over the data path.
module usb_tx_sched #(
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned IPG_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hs_req,
    input  logic [3:0]            hs_pid,
    output logic                  hs_gnt,
    input  logic                  dat_req,
    input  logic [3:0]            dat_pid,
    input  logic [6:0]            dat_len,
    output logic                  dat_gnt,
    input  logic [7:0]            pl_data,
    output logic                  pl_rd,
    output logic                  done,
    usb_tx_sched_if.master        tx
);
    localparam int unsigned LEN_W = 7;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned CRC_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        PID,
        PAYLOAD,
        CRC_LO,
        CRC_HI,
        EOP_WAIT,
        GAP
    } state_t;

    state_t             state;
    logic [3:0]         pid_q;
    logic               is_dat_q;
    logic [LEN_W-1:0]   rem_q;
    logic [GAP_W-1:0]   gap_q;
    logic [CRC_W-1:0]   crc_q;
    logic [7:0]         tx_data_c;
    logic [LEN_W-1:0]   len_clamp_c;
    logic               idle_go_c;
    logic               grant_hs_c;
    logic               grant_dat_c;

    // One byte of the USB CRC16 (reflected 0x8005), LSB of the byte first
    function automatic logic [CRC_W-1:0] crc16_upd(input logic [CRC_W-1:0] crc,
                                                   input logic [7:0]       d);
        logic [CRC_W-1:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign len_clamp_c = (32'(dat_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : dat_len;
    assign idle_go_c   = (state == IDLE) && (hs_req || dat_req) && !tx.tx_busy;

`ifdef USB_TX_SCHED_RR_EN
    logic last_hs_q;

    // Remember the most recent winner so simultaneous requests alternate
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_hs_q <= 1'b0;
        end else if (idle_go_c) begin
            last_hs_q <= grant_hs_c;
        end
    end

    assign grant_hs_c = hs_req && (!dat_req || !last_hs_q);
`else
    assign grant_hs_c = hs_req;
`endif
    assign grant_dat_c = dat_req && !grant_hs_c;

    // Packet sequencer: grant, PID, payload, CRC, wait for line release, gap
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pid_q    <= 4'h0;
            is_dat_q <= 1'b0;
            rem_q    <= '0;
            gap_q    <= '0;
            crc_q    <= 16'hFFFF;
            hs_gnt   <= 1'b0;
            dat_gnt  <= 1'b0;
            done     <= 1'b0;
        end else begin
            hs_gnt  <= 1'b0;
            dat_gnt <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_go_c) begin
                        hs_gnt   <= grant_hs_c;
                        dat_gnt  <= grant_dat_c;
                        is_dat_q <= grant_dat_c;
                        pid_q    <= grant_hs_c ? hs_pid : dat_pid;
                        rem_q    <= grant_hs_c ? '0 : len_clamp_c;
                        crc_q    <= 16'hFFFF;
                        state    <= PID;
                    end
                end
                PID: begin
                    if (tx.tx_ready) begin
                        if (!is_dat_q) begin
                            state <= EOP_WAIT;
                        end else if (rem_q == '0) begin
                            state <= CRC_LO;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (tx.tx_ready) begin
                        crc_q <= crc16_upd(crc_q, pl_data);
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state <= CRC_LO;
                        end
                    end
                end
                CRC_LO: begin
                    if (tx.tx_ready) begin
                        state <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (tx.tx_ready) begin
                        state <= EOP_WAIT;
                    end
                end
                EOP_WAIT: begin
                    if (!tx.tx_busy) begin
                        gap_q <= GAP_W'(IPG_CYCLES);
                        state <= GAP;
                    end
                end
                GAP: begin
                    gap_q <= gap_q - GAP_W'(1);
                    if (gap_q <= GAP_W'(1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte mux; payload passes straight from the FWFT head so it is current
    always_comb begin
        tx_data_c = 8'h00;
        case (state)
            PID:     tx_data_c = {~pid_q, pid_q};
            PAYLOAD: tx_data_c = pl_data;
            CRC_LO:  tx_data_c = ~crc_q[7:0];
            CRC_HI:  tx_data_c = ~crc_q[15:8];
            default: tx_data_c = 8'h00;
        endcase
    end

    assign tx.tx_data  = tx_data_c;
    assign tx.tx_valid = (state == PID) || (state == PAYLOAD) ||
                         (state == CRC_LO) || (state == CRC_HI);
    // Pop coincides with the transmitter taking a payload byte
    assign pl_rd       = reset && (state == PAYLOAD) && tx.tx_ready;

endmodule
